if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage RISCVX pipeline, directly upstream of ID.

---
 rtl/riscvx_pkg.sv | 14 +
 rtl/if_id_reg.sv | 28 ++
 rtl/if_stage.sv | 95 +++++++++
 tb/tb_if_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscvx_pkg.sv
// rtl/riscvx_pkg.sv - shared RISCVX core types and constants
package riscvx_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - hold/bubble/load pipeline register for one instruction slot
module if_id_reg #(
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               bubble,
  input  riscvx_pkg::if_id_t d,
  output riscvx_pkg::if_id_t q
);

  import riscvx_pkg::*;

  if_id_t bubble_val;

  assign bubble_val = '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};

  // bubble beats hold; hold beats load; reset forces a bubble
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q <= bubble_val;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC mux, fetch tracking and IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          IMEM_AW   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               stall,
  input  logic               j_br,
  input  logic [31:0]        BTA,
  input  logic [31:0]        Instr_IF,
  output logic [31:0]        PC_next,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        PC_IF,
  output logic [31:0]        PC_ID,
  output logic [31:0]        Instr_ID,
  output logic               valid_ID,
  output logic [31:0]        fetch_cnt
);

  import riscvx_pkg::*;

  // fetch_valid: the word on Instr_IF really belongs to PC_IF (1-cycle BRAM latency)
  logic   fetch_valid;
  logic   ifid_hold;
  logic   ifid_bubble;
  logic   ifid_load;
  if_id_t ifid_d;
  if_id_t ifid_q;

  // next fetch address; re-presenting PC_IF makes the BRAM re-read the same word
  always_comb begin
    PC_next = PC_IF + 32'd4;
    if (reset) begin
      PC_next = RESET_PC;
    end else if (j_br) begin
      PC_next = BTA & ~32'd3;
    end else if (!fetch_valid || stall || !run) begin
      PC_next = PC_IF;
    end
  end

  assign imem_addr = PC_next[IMEM_AW+1:2];

  // a redirect takes priority over a stall: the stalled ID instruction is wrong-path
  assign ifid_bubble = j_br || (!stall && (!run || !fetch_valid));
  assign ifid_hold   = !j_br && stall;
  assign ifid_load   = !j_br && !stall && run && fetch_valid;
  assign ifid_d      = '{pc: PC_IF, instr: Instr_IF, valid: 1'b1};

  // PC register tracks the address presented to the I_Cache last cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_IF <= RESET_PC;
    end else begin
      PC_IF <= PC_next;
    end
  end

  // after hold the first read result is stale, so the resumed fetch re-reads PC_IF
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= j_br || run;
    end
  end

  // counts only real instructions entering IF/ID
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
    end else if (ifid_load) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .hold   (ifid_hold),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign PC_ID    = ifid_q.pc;
  assign Instr_ID = ifid_q.instr;
  assign valid_ID = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a synchronous-read instruction memory
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        run;
  logic        stall;
  logic        j_br;
  logic [31:0] BTA;
  logic [31:0] Instr_IF;
  logic [31:0] PC_next;
  logic [9:0]  imem_addr;
  logic [31:0] PC_IF;
  logic [31:0] PC_ID;
  logic [31:0] Instr_ID;
  logic        valid_ID;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [0:1023];
  exp_t        exp_q[$];
  int          total;
  int          bad;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP),
    .IMEM_AW   (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .stall     (stall),
    .j_br      (j_br),
    .BTA       (BTA),
    .Instr_IF  (Instr_IF),
    .PC_next   (PC_next),
    .imem_addr (imem_addr),
    .PC_IF     (PC_IF),
    .PC_ID     (PC_ID),
    .Instr_ID  (Instr_ID),
    .valid_ID  (valid_ID),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) Instr_IF <= mem[imem_addr];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 + i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // monitor: every fresh IF/ID load must match the head of the scoreboard
  always @(posedge clk) begin
    logic held;
    logic rst;
    exp_t e;
    held = stall && !j_br;
    rst  = reset;
    #1;
    if (!rst && valid_ID && !held) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_load: got pc=%h instr=%h, none expected", PC_ID, Instr_ID);
      end else begin
        e = exp_q.pop_front();
        if (PC_ID !== e.pc || Instr_ID !== e.instr) begin
          bad++;
          $display("FAIL ifid_load: got pc=%h instr=%h, want pc=%h instr=%h",
                   PC_ID, Instr_ID, e.pc, e.instr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_empty(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected loads missing, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_pc_if"}, PC_IF, 32'h0);
    chk({name, "_pc_id"}, PC_ID, 32'h0);
    chk({name, "_instr_id"}, Instr_ID, NOP);
    chk({name, "_valid_id"}, {31'd0, valid_ID}, 32'd0);
    chk({name, "_fetch_cnt"}, fetch_cnt, 32'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    run   = 1'b1;
    stall = 1'b0;
    j_br  = 1'b0;
    BTA   = 32'h0;
    tick(3);
    chk_reset_state("reset");
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    run   = 1'b0;
    stall = 1'b0;
    j_br  = 1'b0;
    BTA   = 32'h0;

    // straight-line fetch after reset
    reset_dut();
    push(32'h0, 32'hA5A5_0000);
    push(32'h4, 32'hA5A5_0001);
    push(32'h8, 32'hA5A5_0002);
    push(32'hC, 32'hA5A5_0003);
    tick();
    chk("t1_first_bubble", {31'd0, valid_ID}, 32'd0);
    tick(4);
    chk("t1_fetch_cnt", fetch_cnt, 32'd4);
    chk_empty("t1_queue");

    // load-use stall for three cycles while PC_ID=4
    reset_dut();
    push(32'h0, 32'hA5A5_0000);
    push(32'h4, 32'hA5A5_0001);
    push(32'h8, 32'hA5A5_0002);
    push(32'hC, 32'hA5A5_0003);
    tick(3);
    stall = 1'b1;
    #1;
    chk("t2_pc_next_0", PC_next, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_pc", PC_ID, 32'h4);
      chk("t2_hold_instr", Instr_ID, 32'hA5A5_0001);
      chk("t2_hold_valid", {31'd0, valid_ID}, 32'd1);
      if (i < 2) begin
        #1;
        chk("t2_pc_next", PC_next, 32'h8);
      end
    end
    stall = 1'b0;
    tick(2);
    chk("t2_fetch_cnt", fetch_cnt, 32'd4);
    chk_empty("t2_queue");

    // redirect to 0x40 while PC_IF=C
    reset_dut();
    push(32'h0, 32'hA5A5_0000);
    push(32'h4, 32'hA5A5_0001);
    push(32'h8, 32'hA5A5_0002);
    push(32'h40, 32'hA5A5_0010);
    push(32'h44, 32'hA5A5_0011);
    tick(4);
    chk("t3_pc_if", PC_IF, 32'hC);
    j_br = 1'b1;
    BTA  = 32'h40;
    #1;
    chk("t3_pc_next", PC_next, 32'h40);
    tick();
    j_br = 1'b0;
    chk("t3_bubble", {31'd0, valid_ID}, 32'd0);
    chk("t3_pc_if_target", PC_IF, 32'h40);
    tick(2);
    chk("t3_fetch_cnt", fetch_cnt, 32'd5);
    chk_empty("t3_queue");

    // redirect and stall together, misaligned target
    reset_dut();
    push(32'h0, 32'hA5A5_0000);
    push(32'h4, 32'hA5A5_0001);
    push(32'h8, 32'hA5A5_0002);
    push(32'h20, 32'hA5A5_0008);
    push(32'h24, 32'hA5A5_0009);
    tick(4);
    j_br  = 1'b1;
    stall = 1'b1;
    BTA   = 32'h23;
    #1;
    chk("t4_pc_next", PC_next, 32'h20);
    tick();
    j_br  = 1'b0;
    stall = 1'b0;
    chk("t4_bubble", {31'd0, valid_ID}, 32'd0);
    tick(2);
    chk_empty("t4_queue");

    // run drops for five cycles at PC_IF=0x10
    reset_dut();
    push(32'h0, 32'hA5A5_0000);
    push(32'h4, 32'hA5A5_0001);
    push(32'h8, 32'hA5A5_0002);
    push(32'hC, 32'hA5A5_0003);
    push(32'h10, 32'hA5A5_0004);
    push(32'h14, 32'hA5A5_0005);
    tick(5);
    chk("t5_pc_if", PC_IF, 32'h10);
    run = 1'b0;
    #1;
    chk("t5_pc_next_0", PC_next, 32'h10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_bubble", {31'd0, valid_ID}, 32'd0);
      chk("t5_hold_pc_next", PC_next, 32'h10);
    end
    run = 1'b1;
    #1;
    chk("t5_resume_pc_next", PC_next, 32'h10);
    tick();
    chk("t5_resume_bubble", {31'd0, valid_ID}, 32'd0);
    tick(2);
    chk("t5_fetch_cnt", fetch_cnt, 32'd6);
    chk_empty("t5_queue");

    // PC wrap at the top of the address space, then reset mid-stream
    reset_dut();
    push(32'h0, 32'hA5A5_0000);
    push(32'hFFFF_FFFC, 32'hA5A5_03FF);
    push(32'h0, 32'hA5A5_0000);
    tick(2);
    j_br = 1'b1;
    BTA  = 32'hFFFF_FFFC;
    tick();
    j_br = 1'b0;
    #1;
    chk("t6_pc_next_wrap", PC_next, 32'h0);
    chk("t6_imem_addr_wrap", {22'd0, imem_addr}, 32'h0);
    tick(2);
    chk("t6_fetch_cnt", fetch_cnt, 32'd3);
    chk_empty("t6_queue");
    reset = 1'b1;
    #1;
    chk("t6_pc_next_reset", PC_next, 32'h0);
    chk("t6_pc_if_pre", PC_IF, 32'h4);
    tick();
    chk_reset_state("t6_midreset");
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
